// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and defaults for the add-shift multiplier sequencer
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

  localparam int MULT_N_DEFAULT = 8;

endpackage

// File: rtl/step_counter.sv
// rtl/step_counter.sv - clear/increment iteration counter with a flag on the final iteration
module step_counter
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT,
  parameter int W = $clog2(N + 1)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  input  logic         Inc,
  output logic [W-1:0] Count,
  output logic         Last
);

  // Count completed shifts; saturate at N so the display never wraps
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (Inc && (Count != W'(N))) begin
      Count <= Count + 1'b1;
    end
  end

  assign Last = (Count == W'(N - 1));

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - control FSM for the add-shift multiplier; MULT_SIGNED_EN selects signed product
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Run,
  input  logic                     ClearA_LoadB,
  input  logic                     M,
  output logic                     Clr_Ld,
  output logic                     ClearAX,
  output logic                     Add,
  output logic                     Sub,
  output logic                     Shift,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(N+1)-1:0]   Step
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_CLEAR = CLEAR;
  localparam logic [2:0] S_ADD   = ADD;
  localparam logic [2:0] S_SHIFT = SHIFT;
  localparam logic [2:0] S_HOLD  = HOLD;

  logic [2:0] state;
  logic [2:0] state_next;
  logic       last_iter;
  logic       in_add;

  step_counter #(.N(N)) u_step_counter (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (state == S_CLEAR),
    .Inc   (state == S_SHIFT),
    .Count (Step),
    .Last  (last_iter)
  );

  // State register; reset drops straight to IDLE without waiting for a clock
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: load request beats Run in IDLE, HOLD waits for button release
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!ClearA_LoadB && Run) state_next = S_CLEAR;
      S_CLEAR: state_next = S_ADD;
      S_ADD:   state_next = S_SHIFT;
      S_SHIFT: state_next = last_iter ? S_HOLD : S_ADD;
      S_HOLD:  if (!Run) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign in_add = (state == S_ADD);

  // Strobes: Add/Sub follow the live multiplier bit, everything else is decoded from state
  always_comb begin
    Clr_Ld  = (state == S_IDLE) && ClearA_LoadB && !Reset;
    ClearAX = (state == S_CLEAR);
    Shift   = (state == S_SHIFT);
    Busy    = (state == S_CLEAR) || (state == S_ADD) || (state == S_SHIFT);
    Done    = (state == S_HOLD);
`ifdef MULT_SIGNED_EN
    // The final partial product carries negative weight in two's complement
    Add     = in_add && M && !last_iter;
    Sub     = in_add && M && last_iter;
`else
    Add     = in_add && M;
    Sub     = 1'b0;
`endif
  end

endmodule
